// File: rtl/branch_pred_unit.sv
// Direct-mapped branch history/target table with 2-bit counters, a fetch-stage
// lookup, a decode-stage copy of the prediction and decode-time redirect logic.
module branch_pred_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16,
  localparam int IDXW       = $clog2(BHT_ENTRIES),
  localparam int TAGW       = XLEN - IDXW - 2
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            res_valid,
  input  logic [XLEN-1:0] res_pc,
  input  logic            res_taken,
  input  logic [XLEN-1:0] res_target,
  output logic            mispredict,
  output logic [XLEN-1:0] correct_pc
);

  logic [BHT_ENTRIES-1:0] valid_q;
  logic [TAGW-1:0]        tag_q [BHT_ENTRIES];
  logic [XLEN-1:0]        tgt_q [BHT_ENTRIES];
  logic [1:0]             ctr_q [BHT_ENTRIES];

  logic            dec_taken_q;
  logic [XLEN-1:0] dec_target_q;

  logic [IDXW-1:0] f_idx;
  logic [TAGW-1:0] f_tag;
  logic [IDXW-1:0] r_idx;
  logic [TAGW-1:0] r_tag;
  logic            r_hit;
  logic [1:0]      ctr_d;

  assign f_idx = fetch_pc[IDXW+1:2];
  assign f_tag = fetch_pc[XLEN-1:IDXW+2];
  assign r_idx = res_pc[IDXW+1:2];
  assign r_tag = res_pc[XLEN-1:IDXW+2];

  // Lookup reads the registered table, so a same-cycle update is seen next cycle.
  assign pred_taken  = valid_q[f_idx] && (tag_q[f_idx] == f_tag) && ctr_q[f_idx][1];
  assign pred_target = pred_taken ? tgt_q[f_idx] : fetch_pc + XLEN'(4);

  // An invalid entry counts as a tag miss: a taken branch allocates it at weak-taken.
  assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

  always_comb begin
    ctr_d = ctr_q[r_idx];
    if (res_taken) begin
      if (!r_hit)                    ctr_d = 2'd2;
      else if (ctr_q[r_idx] != 2'd3) ctr_d = ctr_q[r_idx] + 2'd1;
    end else if (ctr_q[r_idx] != 2'd0) begin
      ctr_d = ctr_q[r_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid_q <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= 2'd1;
      end
    end else if (res_valid && (res_taken || r_hit)) begin
      ctr_q[r_idx] <= ctr_d;
      if (res_taken) begin
        valid_q[r_idx] <= 1'b1;
        tag_q[r_idx]   <= r_tag;
        tgt_q[r_idx]   <= res_target;
      end
    end
  end

  // Flush kills only the taken bit; the target copy still follows stall.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dec_taken_q  <= 1'b0;
      dec_target_q <= '0;
    end else begin
      if (flush)       dec_taken_q <= 1'b0;
      else if (!stall) dec_taken_q <= pred_taken;
      if (!stall)      dec_target_q <= pred_target;
    end
  end

  assign mispredict = nrst && res_valid &&
                      ((res_taken != dec_taken_q) ||
                       (res_taken && (res_target != dec_target_q)));
  assign correct_pc = res_taken ? res_target : res_pc + XLEN'(4);

endmodule

// File: tb/tb_branch_pred_unit.sv
// Directed bench for branch_pred_unit: a table model keyed by plain integer
// arithmetic checked every cycle, plus hand-computed scenario expectations.
module tb_branch_pred_unit;

  logic        clk;
  logic        nrst;
  logic        stall;
  logic        flush;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic        mispredict;
  logic [31:0] correct_pc;

  int checks   = 0;
  int failures = 0;

  branch_pred_unit dut (
    .clk(clk), .nrst(nrst), .stall(stall), .flush(flush),
    .fetch_pc(fetch_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
    .res_target(res_target), .mispredict(mispredict), .correct_pc(correct_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit          m_v   [16];
  int unsigned m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_ctr [16];
  bit          m_dtaken;
  logic [31:0] m_dtarget;

  function automatic int m_index(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int i = m_index(pc);
    return m_v[i] && (m_tag[i] == int'(pc / 64));
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[m_index(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_ptarget(input logic [31:0] pc);
    logic [31:0] nxt = pc + 32'd4;
    return m_pred(pc) ? m_tgt[m_index(pc)] : nxt;
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 16; i++) begin
        m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
      end
      m_dtaken  = 0;
      m_dtarget = 0;
    end else begin
      int i;
      bit hit;
      i   = m_index(res_pc);
      hit = m_hit(res_pc);
      if (flush)       m_dtaken = 0;
      else if (!stall) m_dtaken = m_pred(fetch_pc);
      if (!stall)      m_dtarget = m_ptarget(fetch_pc);
      if (res_valid) begin
        if (res_taken) begin
          m_ctr[i] = hit ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : 2;
          m_v[i]   = 1;
          m_tag[i] = int'(res_pc / 64);
          m_tgt[i] = res_target;
        end else if (hit) begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", name, got, exp);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!nrst) begin
      chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
      chk("rst_pred_target", pred_target, fetch_pc + 32'd4);
      chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
    end else begin
      bit exp_mp;
      exp_mp = res_valid && ((res_taken != m_dtaken) ||
                             (res_taken && (res_target != m_dtarget)));
      chk("m_pred_taken", {31'd0, pred_taken}, {31'd0, m_pred(fetch_pc)});
      chk("m_pred_target", pred_target, m_ptarget(fetch_pc));
      chk("m_mispredict", {31'd0, mispredict}, {31'd0, exp_mp});
      if (exp_mp)
        chk("m_correct_pc", correct_pc, res_taken ? res_target : res_pc + 32'd4);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_res(input logic v, input logic [31:0] pc, input logic t,
                         input logic [31:0] tgt);
    res_valid  = v;
    res_pc     = pc;
    res_taken  = t;
    res_target = tgt;
  endtask

  initial begin
    nrst = 1'b0; stall = 1'b0; flush = 1'b0;
    fetch_pc = 32'h100;
    set_res(1'b1, 32'h100, 1'b1, 32'h200);
    repeat (2) @(negedge clk);
    chk("reset_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("reset_pred_target", pred_target, 32'h104);
    chk("reset_mispredict", {31'd0, mispredict}, 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1;

    // First taken resolution at 0x100: mispredict, then entry visible.
    @(negedge clk);
    chk("first_mispredict", {31'd0, mispredict}, 32'd1);
    chk("first_correct_pc", correct_pc, 32'h200);
    chk("first_same_cycle_old", {31'd0, pred_taken}, 32'd0);
    tick();
    set_res(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("alloc_pred_taken", {31'd0, pred_taken}, 32'd1);
    chk("alloc_pred_target", pred_target, 32'h200);
    tick();

    // Saturate up, then down.
    set_res(1'b1, 32'h100, 1'b1, 32'h200);
    repeat (3) tick();
    res_taken = 1'b0;
    tick();
    @(negedge clk);
    chk("nt1_still_taken", {31'd0, pred_taken}, 32'd1);
    chk("nt2_mispredict", {31'd0, mispredict}, 32'd1);
    chk("nt2_correct_pc", correct_pc, 32'h104);
    tick();
    @(negedge clk);
    chk("nt2_not_taken", {31'd0, pred_taken}, 32'd0);
    repeat (3) tick();
    res_taken = 1'b1;
    tick();
    set_res(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("ctr_floor_then_inc", {31'd0, pred_taken}, 32'd0);
    chk("ctr_floor_target", pred_target, 32'h104);
    set_res(1'b1, 32'h100, 1'b1, 32'h200);
    repeat (2) tick();

    // Aliasing PC 0x140 shares index 0 with a different tag.
    set_res(1'b1, 32'h140, 1'b0, 32'h0);
    tick();
    set_res(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("alias_nt_unchanged", pred_target, 32'h200);
    fetch_pc = 32'h140; #1;
    chk("alias_lookup_miss", pred_target, 32'h144);
    set_res(1'b1, 32'h140, 1'b1, 32'h300);
    tick();
    set_res(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("replace_pred_target", pred_target, 32'h300);
    fetch_pc = 32'h100; #1;
    chk("replace_old_gone", {31'd0, pred_taken}, 32'd0);
    set_res(1'b1, 32'h140, 1'b0, 32'h0);
    tick();
    set_res(1'b0, 32'h0, 1'b0, 32'h0);
    fetch_pc = 32'h140;
    @(negedge clk);
    chk("replace_ctr_was_2", {31'd0, pred_taken}, 32'd0);

    // Stall holds the decode copy; flush beats stall.
    set_res(1'b1, 32'h140, 1'b1, 32'h300);
    tick();
    set_res(1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_pc = 32'h200 + 32'(4 * i);
      set_res(1'b1, 32'h140, 1'b1, 32'h300);
      @(negedge clk);
      chk("stall_hold_mispredict", {31'd0, mispredict}, 32'd0);
      tick();
    end
    set_res(1'b0, 32'h0, 1'b0, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    stall = 1'b0;
    set_res(1'b1, 32'h140, 1'b1, 32'h300);
    @(negedge clk);
    chk("flush_mispredict", {31'd0, mispredict}, 32'd1);
    chk("flush_correct_pc", correct_pc, 32'h300);
    tick();

    // Top-of-address-space entry and wrap-around.
    fetch_pc = 32'hFFFF_FFFC;
    set_res(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h40);
    tick();
    set_res(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("top_pred_target", pred_target, 32'h40);
    tick();
    set_res(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    @(negedge clk);
    chk("wrap_mispredict", {31'd0, mispredict}, 32'd1);
    chk("wrap_correct_pc", correct_pc, 32'h0);
    chk("same_cycle_old", {31'd0, pred_taken}, 32'd1);
    tick();
    set_res(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("wrap_pred_target", pred_target, 32'h0);
    tick();

    // Asynchronous reset mid-cycle discards the pending update.
    fetch_pc = 32'h140;
    set_res(1'b1, 32'h140, 1'b1, 32'h500);
    #2;
    nrst = 1'b0;
    #1;
    chk("async_rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("async_rst_pred_target", pred_target, 32'h144);
    chk("async_rst_mispredict", {31'd0, mispredict}, 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1;
    set_res(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("post_rst_table_empty", pred_target, 32'h144);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
